interrupt_ctrl: RTL and testbench
=================================

INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 SHALL have parameter FLAG_BASE, default 12'hF00, meaning the address of flag nibble 0; flag nibbles 0-3 occupy FLAG_BASE+0..+3.
REQ-002 SHALL have parameter MASK_BASE, default 12'hF10, meaning the address of mask nibble 0; mask nibbles 0-3 occupy MASK_BASE+0..+3.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port factor_in  input  15  level signals from peripherals (timers, stopwatch, keys, serial); bit i is source i.
REQ-006 SHALL have port memory_write_en  input  1  CPU data-bus write strobe.
REQ-007 SHALL have port memory_read_en  input  1  CPU data-bus read strobe.
REQ-008 SHALL have port memory_addr  input  12  CPU data-bus nibble address.
REQ-009 SHALL have port memory_write_data  input  4  CPU write nibble.
REQ-010 SHALL have port read_data  output  4  registered read nibble.
REQ-011 SHALL have port read_hit  output  1  registered; high when read_data is valid for this block.
REQ-012 SHALL have port interrupt_req  output  15  registered pending-and-enabled requests to the CPU.

Function
REQ-013 SHALL hold prev[14:0], flag[14:0] and mask[14:0] registers.
REQ-014 SHALL update prev <= factor_in every cycle and detect a rise on source i as factor_in[i] & ~prev[i].
REQ-015 SHALL set flag[i] on the cycle after a rise on source i is detected; a level held high sets the flag only once.
REQ-016 SHALL map nibble n (n=0..3) to bits [4n+3:4n]; bit 3 of nibble 3 (bit 15) does not exist, reads 0 and ignores writes.
REQ-017 SHALL, on memory_write_en with memory_addr == MASK_BASE+n, load mask nibble n from memory_write_data at the clock edge.
REQ-018 SHALL ignore writes to flag addresses and to any address outside both windows.
REQ-019 SHALL, on memory_read_en with an address in either window, drive read_data with that nibble's pre-edge value and read_hit=1 on the next cycle (one-cycle latency).
REQ-020 SHALL drive read_hit=0 and read_data=0 the cycle after any cycle without a window-hitting read.
REQ-021 SHALL, on a flag-nibble read, clear the flag bits that were returned as 1, at the same edge that registers read_data (read-to-clear).
REQ-022 SHALL give set priority over clear: a rise on source i in the same cycle as a read clearing flag[i] leaves flag[i]=1 afterwards; that read still returns the pre-edge value.
REQ-023 SHALL treat simultaneous memory_read_en and memory_write_en to the same mask nibble as: read returns old value, write takes effect.
REQ-024 SHALL register interrupt_req <= flag & mask each cycle (one cycle after flag or mask changes).
REQ-025 SHALL have end-to-end latency of 2 clk edges from factor_in rising (sampled) to interrupt_req high when the mask bit is set.
REQ-026 SHALL not clear flags by masking: a masked flag stays pending and raises interrupt_req one cycle after its mask bit is set.
REQ-027 SHALL contain no prioritisation; priority selection is performed downstream by the CPU.

Reset
REQ-028 SHALL, while reset_n=0, asynchronously force prev, flag, mask, interrupt_req, read_data and read_hit to 0.
REQ-029 SHALL, after reset_n deasserts, not generate a flag for a factor_in bit already high at release until it falls and rises again.
REQ-030 SHALL discard any in-flight read response when reset asserts mid-read: read_hit=0 on the first cycle after release.

Verification
REQ-031 SHALL verify: mask nibble 0 written 4'b0001, factor_in[0] 0->1 -> flag[0]=1 next edge; interrupt_req=15'h0001 the edge after; held high, no re-set after clear.
REQ-032 SHALL verify: factor_in[5] rises with mask=0 -> interrupt_req=0; read FLAG_BASE+1 -> read_data=4'b0010, read_hit=1 next cycle; second read -> 4'b0000.
REQ-033 SHALL verify: flag[2]=1 and factor_in[2] rises in the same cycle as a read of FLAG_BASE -> read returns 4'b0100 and flag[2] remains 1.
REQ-034 SHALL verify: write 4'hF to MASK_BASE+3, read it back -> read_data=4'h7; write to FLAG_BASE -> flags unchanged.
REQ-035 SHALL verify: pending masked flag[9], then mask nibble 2 written 4'b0010 -> interrupt_req[9]=1 one cycle after the write edge.
REQ-036 SHALL verify: reset_n pulsed low mid-operation with factor_in=15'h7FFF -> all outputs 0 immediately; no flags after release until factor bits toggle.

Source files
------------

// File: rtl/interrupt_ctrl_if.sv
// CPU data-bus port bundle for interrupt_ctrl: nibble-wide read/write
// strobes, address and data, plus the registered read response.
interface interrupt_ctrl_if;
    logic        memory_write_en;
    logic        memory_read_en;
    logic [11:0] memory_addr;
    logic [3:0]  memory_write_data;
    logic [3:0]  read_data;
    logic        read_hit;

    // CPU side: drives strobes/address/data, receives the read response.
    modport master (
        output memory_write_en,
        output memory_read_en,
        output memory_addr,
        output memory_write_data,
        input  read_data,
        input  read_hit
    );

    // Peripheral side: the interrupt controller.
    modport slave (
        input  memory_write_en,
        input  memory_read_en,
        input  memory_addr,
        input  memory_write_data,
        output read_data,
        output read_hit
    );
endinterface

// File: rtl/interrupt_ctrl.sv
// Interrupt controller: rising-edge detection on 15 peripheral level
// inputs, read-to-clear flag nibbles and writable mask nibbles on the
// CPU data bus, and a registered flag & mask request vector.
module interrupt_ctrl #(
    parameter logic [11:0] FLAG_BASE = 12'hF00,
    parameter logic [11:0] MASK_BASE = 12'hF10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [14:0]             factor_in,
    interrupt_ctrl_if.slave         bus,
    output logic [14:0]             interrupt_req
);

    logic [14:0] prev_q, prev_d;
    logic [14:0] flag_q, flag_d;
    logic [14:0] mask_q, mask_d;
    logic [14:0] interrupt_req_q, interrupt_req_d;
    logic [3:0]  read_data_q, read_data_d;
    logic        read_hit_q, read_hit_d;
    // Low for the first cycle after reset so levels already high at release
    // are absorbed into prev without being seen as a rise.
    logic        armed_q, armed_d;

    logic [11:0] flag_off;
    logic [11:0] mask_off;
    logic        flag_win;
    logic        mask_win;
    logic [15:0] flag_ext;
    logic [15:0] mask_ext;
    logic [14:0] rise;
    logic [14:0] flag_sel;
    logic [14:0] flag_clr;

    // Window decode: an address is inside a window when its offset from the
    // base is 0..3; the low two offset bits select the nibble.
    assign flag_off = bus.memory_addr - FLAG_BASE;
    assign mask_off = bus.memory_addr - MASK_BASE;
    assign flag_win = (flag_off[11:2] == 10'd0);
    assign mask_win = (mask_off[11:2] == 10'd0);

    // Bit 15 of each nibble view does not exist and always reads as 0.
    assign flag_ext = {1'b0, flag_q};
    assign mask_ext = {1'b0, mask_q};

    // Next-state logic for edge detect, flags, mask and the read response.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        prev_d          = factor_in;
        armed_d         = 1'b1;
        rise            = factor_in & ~prev_q & {15{armed_q}};
        flag_sel        = '0;
        read_data_d     = 4'd0;
        read_hit_d      = 1'b0;
        mask_d          = mask_q;

        if (bus.memory_read_en && flag_win) begin
            read_hit_d  = 1'b1;
            read_data_d = flag_ext[{flag_off[1:0], 2'b00} +: 4];
            for (int b = 0; b < 15; b++) begin
                if (flag_off[1:0] == 2'(b / 4)) flag_sel[b] = 1'b1;
            end
        end else if (bus.memory_read_en && mask_win) begin
            // Read sees the pre-edge mask even when written in the same cycle.
            read_hit_d  = 1'b1;
            read_data_d = mask_ext[{mask_off[1:0], 2'b00} +: 4];
        end

        // Only bits actually returned as 1 are cleared; a concurrent rise wins.
        flag_clr = flag_q & flag_sel;
        flag_d   = (flag_q & ~flag_clr) | rise;

        if (bus.memory_write_en && mask_win) begin
            for (int b = 0; b < 15; b++) begin
                if (mask_off[1:0] == 2'(b / 4)) mask_d[b] = bus.memory_write_data[b % 4];
            end
        end

        interrupt_req_d = flag_q & mask_q;
    end

    // State registers, all cleared asynchronously while reset_n is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q          <= '0;
            flag_q          <= '0;
            mask_q          <= '0;
            interrupt_req_q <= '0;
            read_data_q     <= '0;
            read_hit_q      <= 1'b0;
            armed_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            prev_q          <= prev_d;
            flag_q          <= flag_d;
            mask_q          <= mask_d;
            interrupt_req_q <= interrupt_req_d;
            read_data_q     <= read_data_d;
            read_hit_q      <= read_hit_d;
            armed_q         <= armed_d;
        end
    end

    assign interrupt_req = interrupt_req_q;
    assign bus.read_data = read_data_q;
    assign bus.read_hit  = read_hit_q;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl: every bus cycle pushes the expected
// read response onto a scoreboard, popped and compared one edge later.
module tb_interrupt_ctrl;

    localparam logic [11:0] FLAG_BASE = 12'hF00;
    localparam logic [11:0] MASK_BASE = 12'hF10;

    typedef struct {
        string      tag;
        logic       hit;
        logic [3:0] data;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [14:0] factor_in;
    logic [14:0] interrupt_req;

    interrupt_ctrl_if bus ();

    interrupt_ctrl #(
        .FLAG_BASE (FLAG_BASE),
        .MASK_BASE (MASK_BASE)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .factor_in     (factor_in),
        .bus           (bus),
        .interrupt_req (interrupt_req)
    );

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_irq(input string tag, input logic [14:0] exp);
        chk(tag, {1'b0, interrupt_req}, {1'b0, exp});
    endtask

    // One clock edge; then compare the registered read response with the
    // expectation pushed by the stimulus that was present at that edge.
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({"rd_", e.tag}, {11'd0, bus.read_hit, bus.read_data}, {11'd0, e.hit, e.data});
        end else begin
            chk("scoreboard_empty", 16'd1, 16'd0);
        end
        bus.memory_read_en  = 1'b0;
        bus.memory_write_en = 1'b0;
    endtask

    task automatic idle(input string tag);
        sb.push_back('{tag, 1'b0, 4'd0});
        cycle();
    endtask

    task automatic wr(input logic [11:0] addr, input logic [3:0] data, input string tag);
        bus.memory_write_en   = 1'b1;
        bus.memory_addr       = addr;
        bus.memory_write_data = data;
        sb.push_back('{tag, 1'b0, 4'd0});
        cycle();
    endtask

    task automatic rd(input logic [11:0] addr, input logic hit, input logic [3:0] data, input string tag);
        bus.memory_read_en = 1'b1;
        bus.memory_addr    = addr;
        sb.push_back('{tag, hit, data});
        cycle();
    endtask

    task automatic rdwr(input logic [11:0] addr, input logic [3:0] wdata, input logic [3:0] exp_old, input string tag);
        bus.memory_read_en    = 1'b1;
        bus.memory_write_en   = 1'b1;
        bus.memory_addr       = addr;
        bus.memory_write_data = wdata;
        sb.push_back('{tag, 1'b1, exp_old});
        cycle();
    endtask

    initial begin
        reset_n               = 1'b0;
        factor_in             = '0;
        bus.memory_write_en   = 1'b0;
        bus.memory_read_en    = 1'b0;
        bus.memory_addr       = '0;
        bus.memory_write_data = '0;

        // Reset state
        idle("reset0");
        idle("reset1");
        chk_irq("reset_irq", 15'h0000);
        reset_n = 1'b1;

        // Single source, unmasked: flag then request two edges after the rise
        wr(MASK_BASE, 4'b0001, "wr_mask0");
        factor_in = 15'h0001;
        idle("t1_rise");
        chk_irq("t1_irq_after_flag", 15'h0000);
        idle("t1_req");
        chk_irq("t1_irq_set", 15'h0001);
        rd(FLAG_BASE, 1'b1, 4'b0001, "t1_flag_read");
        chk_irq("t1_irq_still", 15'h0001);
        idle("t1_after_clear");
        chk_irq("t1_irq_cleared", 15'h0000);
        idle("t1_held");
        idle("t1_held2");
        chk_irq("t1_no_reset_while_held", 15'h0000);
        rd(FLAG_BASE, 1'b1, 4'b0000, "t1_flag_reread");

        // Masked source: flag pending, no request; read-to-clear
        factor_in = 15'h0020;
        idle("t2_rise");
        idle("t2_wait");
        chk_irq("t2_masked_irq", 15'h0000);
        rd(FLAG_BASE + 12'd1, 1'b1, 4'b0010, "t2_flag1_read");
        rd(FLAG_BASE + 12'd1, 1'b1, 4'b0000, "t2_flag1_reread");

        // Set beats clear when a rise coincides with the clearing read
        factor_in = 15'h0000;
        idle("t3_low");
        factor_in = 15'h0004;
        idle("t3_rise1");
        factor_in = 15'h0000;
        idle("t3_fall");
        factor_in = 15'h0004;
        rd(FLAG_BASE, 1'b1, 4'b0100, "t3_read_with_rise");
        rd(FLAG_BASE, 1'b1, 4'b0100, "t3_flag_survived");
        rd(FLAG_BASE, 1'b1, 4'b0000, "t3_flag_cleared");

        // Mask nibble 3 has only three bits; flag writes and stray addresses ignored
        factor_in = 15'h0000;
        wr(MASK_BASE + 12'd3, 4'hF, "t4_wr_mask3");
        rd(MASK_BASE + 12'd3, 1'b1, 4'h7, "t4_mask3_read");
        factor_in = 15'h0002;
        idle("t4_rise1");
        factor_in = 15'h0000;
        wr(FLAG_BASE, 4'hF, "t4_wr_flag");
        rd(FLAG_BASE, 1'b1, 4'b0010, "t4_flag_unchanged");
        wr(12'h123, 4'hF, "t4_wr_stray");
        rd(12'h123, 1'b0, 4'h0, "t4_rd_stray");
        rd(MASK_BASE, 1'b1, 4'b0001, "t4_mask0_read");
        rdwr(MASK_BASE + 12'd1, 4'h3, 4'h0, "t4_rdwr_old");
        rd(MASK_BASE + 12'd1, 1'b1, 4'h3, "t4_rdwr_new");
        wr(MASK_BASE + 12'd1, 4'h0, "t4_mask1_restore");

        // Pending masked flag raises a request once its mask bit is set
        factor_in = 15'h0200;
        idle("t5_rise");
        factor_in = 15'h0000;
        idle("t5_wait");
        chk_irq("t5_masked", 15'h0000);
        wr(MASK_BASE + 12'd2, 4'b0010, "t5_wr_mask2");
        chk_irq("t5_at_write_edge", 15'h0000);
        idle("t5_after");
        chk_irq("t5_unmasked", 15'h0200);

        // Reset mid-read with every source high
        factor_in = 15'h7FFF;
        rd(FLAG_BASE + 12'd2, 1'b1, 4'b0010, "t6_inflight_read");
        #1;
        reset_n = 1'b0;
        #1;
        chk_irq("t6_irq_in_reset", 15'h0000);
        chk("t6_rd_in_reset", {11'd0, bus.read_hit, bus.read_data}, 16'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle("t6_first_after_release");
        chk_irq("t6_irq_after_release", 15'h0000);
        idle("t6_held1");
        idle("t6_held2");
        rd(FLAG_BASE, 1'b1, 4'h0, "t6_no_flag0");
        rd(FLAG_BASE + 12'd3, 1'b1, 4'h0, "t6_no_flag3");
        factor_in = 15'h0000;
        idle("t6_fall");
        factor_in = 15'h7FFF;
        idle("t6_rise");
        rd(FLAG_BASE + 12'd3, 1'b1, 4'h7, "t6_flag3_after_toggle");
        rd(FLAG_BASE, 1'b1, 4'hF, "t6_flag0_after_toggle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
